// File: rtl/nios_ocimem_arbiter.sv
// Shares the single-port OCIMEM RAM between the CPU debug-slave port and the JTAG
// debug command path; debug reads come back through MonDReg.
module nios_ocimem_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DBG_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic              cpu_waitrequest,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_readdatavalid,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              dbg_overrun,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_writedata,
    input  logic [31:0]       ram_readdata
);

    logic [ADDR_W-1:0] dbg_addr;
    logic              pend;
    logic              pend_wr;
    logic [31:0]       pend_data;
    logic              last_dbg;
    logic              cpu_rd_q;
    logic              dbg_rd_q;
    logic              dbg_wr_q;
    logic [31:0]       cpu_rdata_q;
    logic [31:0]       mon_q;
    logic              overrun_q;

    logic cpu_req;
    logic cpu_grant;
    logic dbg_grant;
    logic strobe;
    logic accept;

    // jdo[1:0] and jdo[37:36] carry nothing this block uses
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    // Per-cycle grant; the queue slot frees on the grant edge, so a strobe there is accepted
    always_comb begin
        cpu_req   = cpu_read | cpu_write;
        cpu_grant = 1'b0;
        dbg_grant = 1'b0;
        if (!reset) begin
            if (pend && cpu_req) begin
                if (DBG_PRIORITY != 0 || !last_dbg) begin
                    dbg_grant = 1'b1;
                end else begin
                    cpu_grant = 1'b1;
                end
            end else begin
                dbg_grant = pend;
                cpu_grant = cpu_req;
            end
        end
        strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        accept = strobe & ~(pend & ~dbg_grant);
    end

    // RAM port follows the winner
    always_comb begin
        ram_address    = '0;
        ram_wren       = 1'b0;
        ram_byteenable = 4'h0;
        ram_writedata  = 32'h0;
        if (cpu_grant) begin
            ram_address    = cpu_address;
            ram_wren       = cpu_write;
            ram_byteenable = cpu_byteenable;
            ram_writedata  = cpu_writedata;
        end else if (dbg_grant) begin
            ram_address    = dbg_addr;
            ram_wren       = pend_wr;
            ram_byteenable = 4'hF;
            ram_writedata  = pend_data;
        end
    end

    // Read data passes straight through in the return cycle and is held afterwards
    assign cpu_waitrequest   = reset | (cpu_req & ~cpu_grant);
    assign cpu_readdatavalid = cpu_rd_q & ~reset;
    assign cpu_readdata      = reset ? 32'h0 : (cpu_rd_q ? ram_readdata : cpu_rdata_q);
    assign MonDReg           = reset ? 32'h0 : (dbg_rd_q ? ram_readdata : mon_q);
    assign monitor_ready     = (dbg_rd_q | dbg_wr_q) & ~reset;
    assign dbg_overrun       = overrun_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_addr    <= '0;
            pend        <= 1'b0;
            pend_wr     <= 1'b0;
            pend_data   <= 32'h0;
            last_dbg    <= 1'b0;
            cpu_rd_q    <= 1'b0;
            dbg_rd_q    <= 1'b0;
            dbg_wr_q    <= 1'b0;
            cpu_rdata_q <= 32'h0;
            mon_q       <= 32'h0;
            overrun_q   <= 1'b0;
        end else begin
            cpu_rd_q <= cpu_grant & ~cpu_write;
            dbg_rd_q <= dbg_grant & ~pend_wr;
            dbg_wr_q <= dbg_grant & pend_wr;
            if (cpu_rd_q) begin
                cpu_rdata_q <= ram_readdata;
            end
            if (dbg_rd_q) begin
                mon_q <= ram_readdata;
            end
            if (cpu_grant || dbg_grant) begin
                last_dbg <= dbg_grant;
            end
            if (dbg_grant) begin
                pend     <= 1'b0;
                dbg_addr <= dbg_addr + ADDR_W'(1);
            end
            if (strobe && !accept) begin
                overrun_q <= 1'b1;
            end
            // Strobe priority: ocimem_a, then ocimem_b, then no_action
            if (accept) begin
                if (take_action_ocimem_a) begin
                    dbg_addr <= jdo[ADDR_W+1:2];
                    if (jdo[35]) begin
                        pend    <= 1'b1;
                        pend_wr <= 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    pend      <= 1'b1;
                    pend_wr   <= 1'b1;
                    pend_data <= jdo[34:3];
                end else begin
                    pend    <= 1'b1;
                    pend_wr <= 1'b0;
                end
            end
        end
    end

endmodule
